// File: rtl/armleocpu_bus_arbiter.sv
// Round-robin arbiter merging several cache-style master ports onto one memory port.
// A grant is held for the whole burst; an error response on any beat ends the burst early.
module armleocpu_bus_arbiter #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 34,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BURST_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [CHANNELS-1:0]          m_transaction,
  input  logic [CHANNELS*3-1:0]        m_cmd,
  input  logic [CHANNELS*ADDR_W-1:0]   m_address,
  input  logic [CHANNELS*BURST_W-1:0]  m_burstcount,
  input  logic [CHANNELS*DATA_W-1:0]   m_wdata,
  input  logic [CHANNELS*DATA_W/8-1:0] m_wbyte_enable,
  output logic [CHANNELS-1:0]          m_transaction_done,
  output logic [2:0]                   m_transaction_response,
  output logic [DATA_W-1:0]            m_rdata,

  output logic                         s_transaction,
  output logic [2:0]                   s_cmd,
  output logic [ADDR_W-1:0]            s_address,
  output logic [BURST_W-1:0]           s_burstcount,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wbyte_enable,
  input  logic                         s_transaction_done,
  input  logic [2:0]                   s_transaction_response,
  input  logic [DATA_W-1:0]            s_rdata
);

  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BeW  = DATA_W / 8;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    gnt_q, gnt_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [BURST_W-1:0] beats_q, beats_d;

  logic [IdxW-1:0]    pick;
  logic               any_req;
  logic [31:0]        gi;
  logic [BURST_W-1:0] cur_burst;
  logic [BURST_W-1:0] last_beat;
  logic               last;

  assign gi        = 32'(gnt_q);
  assign cur_burst = m_burstcount[BURST_W*gi +: BURST_W];
  // A burstcount of zero is treated as a single beat.
  assign last_beat = (cur_burst == '0) ? '0 : cur_burst - 1'b1;
  assign last      = (beats_q == last_beat) || (s_transaction_response != 3'b000);

  // Cyclic search for the first requester at or after ptr.
  always_comb begin
    logic [IdxW-1:0] idx;
    pick    = ptr_q;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = IdxW'((32'(ptr_q) + i) % CHANNELS);
      if (!any_req && m_transaction[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d   = pick;
          state_d = StBusy;
          beats_d = '0;
        end
      end
      StBusy: begin
        if (s_transaction_done) begin
          if (last) begin
            state_d = StIdle;
            ptr_d   = (gnt_q == IdxW'(CHANNELS - 1)) ? '0 : gnt_q + 1'b1;
          end else begin
            beats_d = beats_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    s_transaction      = 1'b0;
    s_cmd              = '0;
    s_address          = '0;
    s_burstcount       = '0;
    s_wdata            = '0;
    s_wbyte_enable     = '0;
    m_transaction_done = '0;
    if (state_q == StBusy) begin
      s_transaction             = 1'b1;
      s_cmd                     = m_cmd[3*gi +: 3];
      s_address                 = m_address[ADDR_W*gi +: ADDR_W];
      s_burstcount              = cur_burst;
      s_wdata                   = m_wdata[DATA_W*gi +: DATA_W];
      s_wbyte_enable            = m_wbyte_enable[BeW*gi +: BeW];
      m_transaction_done[gnt_q] = s_transaction_done;
    end
  end

  assign m_transaction_response = s_transaction_response;
  assign m_rdata                = s_rdata;

endmodule

// File: tb/tb_armleocpu_bus_arbiter.sv
// Randomised bench for armleocpu_bus_arbiter: master/slave models drive traffic, an
// arbitration model predicts grant order into a scoreboard, a negedge monitor checks it.
module tb_armleocpu_bus_arbiter;

  localparam int CH  = 2;
  localparam int AW  = 34;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int BEW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     m_transaction = '0;
  logic [CH*3-1:0]   m_cmd = '0;
  logic [CH*AW-1:0]  m_address = '0;
  logic [CH*BW-1:0]  m_burstcount = '0;
  logic [CH*DW-1:0]  m_wdata = '0;
  logic [CH*BEW-1:0] m_wbyte_enable = '0;
  logic [CH-1:0]     m_transaction_done;
  logic [2:0]        m_transaction_response;
  logic [DW-1:0]     m_rdata;
  logic              s_transaction;
  logic [2:0]        s_cmd;
  logic [AW-1:0]     s_address;
  logic [BW-1:0]     s_burstcount;
  logic [DW-1:0]     s_wdata;
  logic [BEW-1:0]    s_wbyte_enable;
  logic              s_transaction_done = 1'b0;
  logic [2:0]        s_transaction_response = 3'b000;
  logic [DW-1:0]     s_rdata = '0;

  always #5 clk = ~clk;

  armleocpu_bus_arbiter #(
    .CHANNELS(CH),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .BURST_W (BW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .m_transaction         (m_transaction),
    .m_cmd                 (m_cmd),
    .m_address             (m_address),
    .m_burstcount          (m_burstcount),
    .m_wdata               (m_wdata),
    .m_wbyte_enable        (m_wbyte_enable),
    .m_transaction_done    (m_transaction_done),
    .m_transaction_response(m_transaction_response),
    .m_rdata               (m_rdata),
    .s_transaction         (s_transaction),
    .s_cmd                 (s_cmd),
    .s_address             (s_address),
    .s_burstcount          (s_burstcount),
    .s_wdata               (s_wdata),
    .s_wbyte_enable        (s_wbyte_enable),
    .s_transaction_done    (s_transaction_done),
    .s_transaction_response(s_transaction_response),
    .s_rdata               (s_rdata)
  );

  typedef struct {
    int             ch;
    logic [2:0]     cmd;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  burst;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
    int             err;    // 1-based beat that gets an error response, 0 = none
    int             beats;  // beats the arbiter must deliver
  } tx_t;

  tx_t pend_q[$];
  tx_t exp_q[$];
  tx_t cur[CH];
  bit  act[CH];
  bit  fin[CH];
  int  mbeat[CH];
  int  mptr = 0;
  int  total = 0;
  int  bad = 0;
  int  sbeat = 0;
  bit  slow = 1'b0;
  bit  prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int nbeats(input tx_t t);
    return (t.burst == '0) ? 1 : int'(t.burst);
  endfunction

  function automatic int exp_beats(input tx_t t);
    int n;
    n = nbeats(t);
    return (t.err >= 1 && t.err <= n) ? t.err : n;
  endfunction

  task automatic add_tx(input int ch, input int burst, input int err);
    tx_t         t;
    logic [63:0] r;
    r         = {$urandom, $urandom};
    t.ch      = ch;
    t.cmd     = 3'($urandom_range(1, 7));
    t.addr    = r[AW-1:0];
    t.addr[2:0] = 3'(ch);
    t.burst   = BW'(burst);
    t.wdata   = $urandom;
    t.be      = BEW'($urandom);
    t.err     = err;
    t.beats   = exp_beats(t);
    pend_q.push_back(t);
  endtask

  // Grant order: repeatedly pick the first channel with pending work at or after the pointer.
  task automatic plan();
    tx_t tmp[$];
    int  g;
    int  j;
    int  c;
    tmp = pend_q;
    while (tmp.size() > 0) begin
      g = -1;
      j = -1;
      for (int k = 0; k < CH; k++) begin
        c = (mptr + k) % CH;
        if (g < 0) foreach (tmp[x]) if (j < 0 && tmp[x].ch == c) begin g = c; j = x; end
      end
      exp_q.push_back(tmp[j]);
      tmp.delete(j);
      mptr = (g + 1) % CH;
    end
  endtask

  task automatic load(input int ch);
    int j;
    j = -1;
    foreach (pend_q[x]) if (j < 0 && pend_q[x].ch == ch) j = x;
    fin[ch] = 1'b0;
    if (j >= 0) begin
      cur[ch] = pend_q[j];
      pend_q.delete(j);
      act[ch]   = 1'b1;
      mbeat[ch] = 0;
      m_transaction[ch]              = 1'b1;
      m_cmd[3*ch +: 3]               = cur[ch].cmd;
      m_address[AW*ch +: AW]         = cur[ch].addr;
      m_burstcount[BW*ch +: BW]      = cur[ch].burst;
      m_wdata[DW*ch +: DW]           = cur[ch].wdata;
      m_wbyte_enable[BEW*ch +: BEW]  = cur[ch].be;
    end else begin
      act[ch]           = 1'b0;
      m_transaction[ch] = 1'b0;
    end
  endtask

  // One clock of master and slave behaviour.
  task automatic step();
    int c;
    bit d;
    @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      if (act[k] && m_transaction_done[k]) begin
        mbeat[k]++;
        if (mbeat[k] == nbeats(cur[k]) || m_transaction_response != 3'b000) fin[k] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) if (fin[k] || !act[k]) load(k);
    #1;
    if (s_transaction) begin
      c = int'(s_address[2:0]);
      d = slow ? !prev_done : ($urandom_range(0, 3) != 0);
      s_transaction_done     = d;
      s_rdata                = $urandom;
      s_transaction_response = 3'b000;
      if (d && c < CH && cur[c].err == sbeat + 1) s_transaction_response = 3'($urandom_range(1, 7));
      if (d) sbeat++;
      prev_done = d;
    end else begin
      s_transaction_done     = 1'b0;
      s_transaction_response = 3'b000;
      s_rdata                = $urandom;
      sbeat                  = 0;
      prev_done              = 1'b0;
    end
  endtask

  function automatic bit any_act();
    bit a;
    a = 1'b0;
    for (int k = 0; k < CH; k++) a |= act[k];
    return a;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    pend_q.delete();
    m_transaction = '0;
    for (int k = 0; k < CH; k++) begin
      act[k] = 1'b0;
      fin[k] = 1'b0;
    end
    mptr                   = 0;
    s_transaction_done     = 1'b0;
    s_transaction_response = 3'b000;
    sbeat                  = 0;
    prev_done              = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_round();
    int n;
    n = 0;
    plan();
    do begin
      step();
      n++;
    end while ((pend_q.size() > 0 || any_act() || s_transaction) && n < 400);
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL round_timeout: got %0d cycles want <400, %0d grants outstanding", n,
               exp_q.size());
      do_reset();
    end else begin
      step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  // Monitor: pops the predicted transaction on each grant and checks every cycle.
  initial begin
    tx_t me;
    bit  in_tx;
    int  mb;
    int  idle_req;
    in_tx    = 1'b0;
    mb       = 0;
    idle_req = 0;
    me       = '{ch: 0, cmd: '0, addr: '0, burst: '0, wdata: '0, be: '0, err: 0, beats: -1};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_tx    = 1'b0;
        idle_req = 0;
        chk("rst_s_transaction", 64'(s_transaction), 64'd0);
        chk("rst_done", 64'(m_transaction_done), 64'd0);
      end else begin
        chk("rdata_pass", 64'(m_rdata), 64'(s_rdata));
        chk("resp_pass", 64'(m_transaction_response), 64'(s_transaction_response));
        if (s_transaction) begin
          if (!in_tx) begin
            chk("arb_latency", 64'(idle_req), 64'd1);
            idle_req = 0;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_grant: got address %0h want no grant", s_address);
              me.beats = -1;
            end else begin
              me = exp_q.pop_front();
            end
            in_tx = 1'b1;
            mb    = 0;
          end
          chk("s_cmd", 64'(s_cmd), 64'(me.cmd));
          chk("s_address", 64'(s_address), 64'(me.addr));
          chk("s_burstcount", 64'(s_burstcount), 64'(me.burst));
          chk("s_wdata", 64'(s_wdata), 64'(me.wdata));
          chk("s_wbyte_enable", 64'(s_wbyte_enable), 64'(me.be));
          chk("done_vector", 64'(m_transaction_done),
              s_transaction_done ? (64'd1 << me.ch) : 64'd0);
          if (s_transaction_done) mb++;
        end else begin
          if (in_tx) begin
            chk("beat_count", 64'(mb), 64'(me.beats));
            in_tx = 1'b0;
          end
          chk("idle_done", 64'(m_transaction_done), 64'd0);
          chk("idle_s_address", 64'(s_address), 64'd0);
          chk("idle_s_cmd", 64'(s_cmd), 64'd0);
          if (|m_transaction) idle_req++;
          else idle_req = 0;
        end
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < CH; k++) begin
      act[k]   = 1'b0;
      fin[k]   = 1'b0;
      mbeat[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_s_transaction", 64'(s_transaction), 64'd0);
    chk("reset_done", 64'(m_transaction_done), 64'd0);
    chk("reset_s_address", 64'(s_address), 64'd0);
    chk("reset_s_burstcount", 64'(s_burstcount), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read on channel 1.
    add_tx(1, 1, 0);
    run_round();
    // Both channels hold requests for two transactions each: expect 0,1,0,1.
    add_tx(0, 2, 0);
    add_tx(0, 1, 0);
    add_tx(1, 3, 0);
    add_tx(1, 1, 0);
    run_round();
    // Four-beat burst with gapped done pulses while channel 1 waits.
    slow = 1'b1;
    add_tx(0, 4, 0);
    add_tx(1, 1, 0);
    run_round();
    slow = 1'b0;
    // Error on beat 2 of 4 ends the burst early.
    add_tx(0, 4, 2);
    add_tx(1, 2, 0);
    run_round();
    // Zero burstcount acts as one beat.
    add_tx(0, 0, 0);
    add_tx(1, 0, 0);
    run_round();

    // Reset in the middle of beat 2 of a 4-beat burst.
    add_tx(0, 4, 0);
    plan();
    n = 0;
    do begin
      step();
      n++;
    end while (sbeat < 2 && n < 100);
    chk("t6_busy_before_reset", 64'(s_transaction), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_drop", 64'(s_transaction), 64'd0);
    chk("t6_async_done", 64'(m_transaction_done), 64'd0);
    do_reset();
    add_tx(1, 1, 0);
    add_tx(0, 1, 0);
    run_round();

    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          add_tx(c, $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end
      end
      slow = ($urandom_range(0, 4) == 0);
      if (pend_q.size() > 0) run_round();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
